// File: rtl/apu_frame_regs.sv
`default_nettype none
// ============================================================================
//  Module   : apu_frame_regs
//  Purpose  : CPU-facing APU register front end and frame sequencer.
//             Latches CPU writes to $4000-$4007 into pulse register bytes
//             with registered one-clk update strobes, owns $4015 (channel
//             enables / status read) and $4017 (frame mode, IRQ inhibit),
//             and produces quarter/half frame ticks plus the frame IRQ.
//  Ports    : clk, rst           clock, synchronous active-high reset
//             cpu_ce, apu_cycle  CPU-cycle enable, APU half-rate phase
//             addr, wdata, wr    CPU write port (offset from $4000)
//             rd, rdata          CPU read port ($4015 only, comb data)
//             p0_*/p1_*          pulse register bytes and update strobes
//             en                 channel enables {dmc,noise,tri,p1,p0}
//             active, dmc_*      status inputs for the $4015 read
//             qtrframe/halfframe frame ticks, frame_irq interrupt flag
//  Revision : 1.0  initial release
// ============================================================================
module apu_frame_regs #(
  parameter int STEP1 = 7457,
  parameter int STEP2 = 14913,
  parameter int STEP3 = 22371,
  parameter int STEP4 = 29829,
  parameter int STEP5 = 37281
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_ce,
  input  logic       apu_cycle,
  input  logic [4:0] addr,
  input  logic [7:0] wdata,
  input  logic       wr,
  input  logic       rd,
  output logic [7:0] rdata,
  output logic [7:0] p0_ctrl,
  output logic [7:0] p0_sweep,
  output logic [7:0] p0_timelow,
  output logic [7:0] p0_timehigh,
  output logic [7:0] p1_ctrl,
  output logic [7:0] p1_sweep,
  output logic [7:0] p1_timelow,
  output logic [7:0] p1_timehigh,
  output logic       p0_ctrl_update,
  output logic       p0_sweep_update,
  output logic       p0_len_update,
  output logic       p1_ctrl_update,
  output logic       p1_sweep_update,
  output logic       p1_len_update,
  output logic [4:0] en,
  input  logic [3:0] active,
  input  logic       dmc_active,
  input  logic       dmc_irq,
  output logic       qtrframe,
  output logic       halfframe,
  output logic       frame_irq
);

  localparam logic [15:0] T1 = 16'(STEP1);
  localparam logic [15:0] T2 = 16'(STEP2);
  localparam logic [15:0] T3 = 16'(STEP3);
  localparam logic [15:0] T4 = 16'(STEP4);
  localparam logic [15:0] T5 = 16'(STEP5);

  localparam logic [1:0] SEQ_IDLE  = 2'd0;
  localparam logic [1:0] SEQ_WAIT  = 2'd1;
  localparam logic [1:0] SEQ_APPLY = 2'd2;

  logic [1:0]  seq_state, seq_next;
  logic [1:0]  delay, delay_next;
  logic        apply, apply_ticks;
  logic        wr_en, rd_en, wr_4017, rd_4015;
  logic [15:0] count;
  logic [15:0] step_end;
  logic        mode, inhibit;
  logic        step_qtr, step_half, irq_window, wrap;

  assign wr_en   = wr & cpu_ce;
  assign rd_en   = rd & cpu_ce;
  assign wr_4017 = wr_en && (addr == 5'h17);
  assign rd_4015 = rd_en && (addr == 5'h15);

  assign rdata = (addr == 5'h15) ? {dmc_irq, frame_irq, 1'b0, dmc_active, active} : 8'h00;

  // Step comparisons on the count value present at the cpu_ce edge.
  assign step_end   = mode ? T5 : T4;
  assign step_qtr   = (count == T1) || (count == T2) || (count == T3) || (count == step_end);
  assign step_half  = (count == T2) || (count == step_end);
  assign irq_window = !mode && !inhibit &&
                      ((count == T4 - 16'd1) || (count == T4) || (count == T4 + 16'd1));
  assign wrap       = mode ? (count == T5) : (count == T4 + 16'd1);

  // ---------------- delayed counter reset sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_state <= SEQ_IDLE;
      delay     <= 2'd0;
    end else begin
      seq_state <= seq_next;
      delay     <= delay_next;
    end
  end

  // The delay register holds the remaining WAIT edges minus one, so a load
  // of D-1 puts APPLY exactly D cpu_ce edges after the $4017 write.
  always_comb begin
    seq_next   = seq_state;
    delay_next = delay;
    if (wr_4017) begin
      seq_next   = SEQ_WAIT;
      delay_next = apu_cycle ? 2'd2 : 2'd3;
    end else if (cpu_ce) begin
      case (seq_state)
        SEQ_WAIT: begin
          if (delay == 2'd1) seq_next = SEQ_APPLY;
          else               delay_next = delay - 2'd1;
        end
        SEQ_APPLY: seq_next = SEQ_IDLE;
        SEQ_IDLE:  seq_next = SEQ_IDLE;
        default:   seq_next = SEQ_IDLE;
      endcase
    end
  end

  always_comb begin
    apply       = cpu_ce && (seq_state == SEQ_APPLY);
    apply_ticks = apply && mode;
  end

  // ---------------- registers, strobes, counter, IRQ ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_ctrl         <= 8'h00;
      p0_sweep        <= 8'h00;
      p0_timelow      <= 8'h00;
      p0_timehigh     <= 8'h00;
      p1_ctrl         <= 8'h00;
      p1_sweep        <= 8'h00;
      p1_timelow      <= 8'h00;
      p1_timehigh     <= 8'h00;
      p0_ctrl_update  <= 1'b0;
      p0_sweep_update <= 1'b0;
      p0_len_update   <= 1'b0;
      p1_ctrl_update  <= 1'b0;
      p1_sweep_update <= 1'b0;
      p1_len_update   <= 1'b0;
      en              <= 5'd0;
      mode            <= 1'b0;
      inhibit         <= 1'b0;
      frame_irq       <= 1'b0;
      count           <= 16'd0;
      qtrframe        <= 1'b0;
      halfframe       <= 1'b0;
    end else begin
      // A timehigh write also restarts the envelope, hence ctrl_update.
      p0_ctrl_update  <= wr_en && ((addr == 5'h00) || (addr == 5'h03));
      p0_sweep_update <= wr_en && (addr == 5'h01);
      p0_len_update   <= wr_en && (addr == 5'h03);
      p1_ctrl_update  <= wr_en && ((addr == 5'h04) || (addr == 5'h07));
      p1_sweep_update <= wr_en && (addr == 5'h05);
      p1_len_update   <= wr_en && (addr == 5'h07);

      qtrframe  <= cpu_ce && (step_qtr || apply_ticks);
      halfframe <= cpu_ce && (step_half || apply_ticks);

      if (wr_en) begin
        case (addr)
          5'h00: p0_ctrl     <= wdata;
          5'h01: p0_sweep    <= wdata;
          5'h02: p0_timelow  <= wdata;
          5'h03: p0_timehigh <= wdata;
          5'h04: p1_ctrl     <= wdata;
          5'h05: p1_sweep    <= wdata;
          5'h06: p1_timelow  <= wdata;
          5'h07: p1_timehigh <= wdata;
          5'h15: en          <= wdata[4:0];
          5'h17: begin
            mode    <= wdata[7];
            inhibit <= wdata[6];
          end
          default: ;
        endcase
      end

      if (cpu_ce) begin
        if (apply || wrap) count <= 16'd0;
        else               count <= count + 16'd1;

        // Inhibit clear beats a set; a set beats the status-read clear.
        if (wr_4017 && wdata[6]) frame_irq <= 1'b0;
        else if (irq_window)     frame_irq <= 1'b1;
        else if (rd_4015)        frame_irq <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apu_frame_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apu_frame_regs
//  Purpose  : Directed self-checking bench for apu_frame_regs. The step
//             parameters are scaled down so whole frames run quickly; the
//             expected edge counts below are derived from these values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apu_frame_regs;

  localparam int S1 = 37;
  localparam int S2 = 73;
  localparam int S3 = 111;
  localparam int S4 = 149;
  localparam int S5 = 186;

  localparam int SEL_QTR  = 0;
  localparam int SEL_HALF = 1;
  localparam int SEL_IRQ  = 2;

  logic       clk, rst, cpu_ce, apu_cycle, wr, rd;
  logic [4:0] addr;
  logic [7:0] wdata, rdata;
  logic [7:0] p0_ctrl, p0_sweep, p0_timelow, p0_timehigh;
  logic [7:0] p1_ctrl, p1_sweep, p1_timelow, p1_timehigh;
  logic       p0_ctrl_update, p0_sweep_update, p0_len_update;
  logic       p1_ctrl_update, p1_sweep_update, p1_len_update;
  logic [4:0] en;
  logic [3:0] active;
  logic       dmc_active, dmc_irq;
  logic       qtrframe, halfframe, frame_irq;

  int checks = 0;
  int errors = 0;
  int n;

  apu_frame_regs #(.STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5)) dut (
    .clk(clk), .rst(rst), .cpu_ce(cpu_ce), .apu_cycle(apu_cycle),
    .addr(addr), .wdata(wdata), .wr(wr), .rd(rd), .rdata(rdata),
    .p0_ctrl(p0_ctrl), .p0_sweep(p0_sweep), .p0_timelow(p0_timelow), .p0_timehigh(p0_timehigh),
    .p1_ctrl(p1_ctrl), .p1_sweep(p1_sweep), .p1_timelow(p1_timelow), .p1_timehigh(p1_timehigh),
    .p0_ctrl_update(p0_ctrl_update), .p0_sweep_update(p0_sweep_update), .p0_len_update(p0_len_update),
    .p1_ctrl_update(p1_ctrl_update), .p1_sweep_update(p1_sweep_update), .p1_len_update(p1_len_update),
    .en(en), .active(active), .dmc_active(dmc_active), .dmc_irq(dmc_irq),
    .qtrframe(qtrframe), .halfframe(halfframe), .frame_irq(frame_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    step();
    wr    = 1'b0;
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      SEL_QTR:  return qtrframe;
      SEL_HALF: return halfframe;
      default:  return frame_irq;
    endcase
  endfunction

  // Number of edges until the selected output is seen high; 0 on timeout.
  task automatic wait_for(input int sel, input int budget, output int edges);
    bit done;
    done  = 1'b0;
    edges = 0;
    for (int i = 1; i <= budget && !done; i++) begin
      step();
      if (sel_sig(sel)) begin
        edges = i;
        done  = 1'b1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cpu_ce = 1'b1; apu_cycle = 1'b0; wr = 1'b0; rd = 1'b0;
    addr = 5'h00; wdata = 8'h00;
    active = 4'b0101; dmc_active = 1'b1; dmc_irq = 1'b0;
    step(); step(); step();

    // reset state
    check("rst_p0_ctrl", p0_ctrl, 8'h00);
    check("rst_p1_timehigh", p1_timehigh, 8'h00);
    check("rst_strobes", {p0_ctrl_update, p0_sweep_update, p0_len_update,
                          p1_ctrl_update, p1_sweep_update, p1_len_update}, 6'd0);
    check("rst_en", en, 5'd0);
    check("rst_ticks_irq", {qtrframe, halfframe, frame_irq}, 3'd0);
    rst = 1'b0;

    // register writes and strobes
    cpu_write(5'h02, 8'h34);
    check("timelow_data", p0_timelow, 8'h34);
    check("timelow_nostrobe", {p0_ctrl_update, p0_sweep_update, p0_len_update}, 3'b000);
    cpu_write(5'h03, 8'h0B);
    check("timehigh_data", p0_timehigh, 8'h0B);
    check("timehigh_strobes", {p0_ctrl_update, p0_sweep_update, p0_len_update}, 3'b101);
    step();
    check("timehigh_strobe_drop", {p0_ctrl_update, p0_len_update}, 2'b00);
    check("timehigh_hold", p0_timehigh, 8'h0B);
    cpu_write(5'h05, 8'hA5);
    check("p1_sweep", {p1_sweep, p1_sweep_update, p0_sweep_update}, {8'hA5, 2'b10});
    cpu_write(5'h04, 8'h3F);
    check("p1_ctrl", {p1_ctrl, p1_ctrl_update, p1_len_update}, {8'h3F, 2'b10});
    cpu_write(5'h07, 8'hC1);
    check("p1_timehigh", {p1_timehigh, p1_ctrl_update, p1_len_update}, {8'hC1, 2'b11});
    cpu_write(5'h08, 8'hFF);
    check("unmapped", {p0_ctrl, p0_sweep, p1_timelow}, 24'd0);
    cpu_ce = 1'b0;
    cpu_write(5'h00, 8'h77);
    check("write_no_ce", {p0_ctrl, 7'd0, p0_ctrl_update}, 16'd0);
    cpu_ce = 1'b1;
    cpu_write(5'h15, 8'h03);
    check("en_write", en, 5'b00011);
    addr = 5'h15;
    #1 check("rd_4015", rdata, 8'h15);
    addr = 5'h02;
    #1 check("rd_other", rdata, 8'h00);

    // fresh reset, then 4-step free run
    rst = 1'b1;
    step();
    check("rst2_clears", {en, p0_timehigh}, 13'd0);
    rst = 1'b0;
    wait_for(SEL_QTR, 300, n);
    check("free_step1", n, S1 + 1);
    check("free_step1_half", halfframe, 1'b0);
    wait_for(SEL_QTR, 300, n);
    check("free_step2", n, S2 - S1);
    check("free_step2_half", halfframe, 1'b1);
    wait_for(SEL_QTR, 300, n);
    check("free_step3", n, S3 - S2);
    check("free_step3_half", halfframe, 1'b0);
    wait_for(SEL_IRQ, 300, n);
    check("irq_rise", n, S4 - 1 - S3);
    check("irq_rise_noqtr", qtrframe, 1'b0);
    // read coincident with a set: the set wins
    addr = 5'h15; rd = 1'b1;
    #1 check("rd_irq_bit", rdata, 8'h55);
    step();
    check("set_wins_read", frame_irq, 1'b1);
    check("free_step4", {qtrframe, halfframe}, 2'b11);
    rd = 1'b0;
    step();
    check("irq_still_set", frame_irq, 1'b1);
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("read_clears_irq", frame_irq, 1'b0);
    check("rd_after_clear", rdata, 8'h15);
    wait_for(SEL_QTR, 300, n);
    check("wrap_step1", n, S1);

    // inhibit: $4017=0x40 with apu_cycle=0 delays the counter reset by 4
    cpu_write(5'h17, 8'h40);
    wait_for(SEL_QTR, 300, n);
    check("d4_step1", n, 4 + S1 + 1);
    wait_for(SEL_QTR, 300, n);
    check("inh_step2", n, S2 - S1);
    wait_for(SEL_QTR, 300, n);
    check("inh_step3", n, S3 - S2);
    wait_for(SEL_QTR, 300, n);
    check("inh_step4", n, S4 - S3);
    check("inh_step4_half", halfframe, 1'b1);
    check("inh_no_irq", frame_irq, 1'b0);
    step();
    check("inh_no_irq_after", frame_irq, 1'b0);

    // 5-step: $4017=0x80 with apu_cycle=1 applies after 3 edges with ticks
    apu_cycle = 1'b1;
    cpu_write(5'h17, 8'h80);
    apu_cycle = 1'b0;
    step();
    check("d3_wait1", {qtrframe, halfframe}, 2'b00);
    step();
    check("d3_wait2", {qtrframe, halfframe}, 2'b00);
    step();
    check("d3_apply_ticks", {qtrframe, halfframe}, 2'b11);
    cpu_ce = 1'b0;
    step();
    check("tick_drop_no_ce", {qtrframe, halfframe}, 2'b00);
    for (int i = 0; i < 9; i++) step();
    cpu_ce = 1'b1;
    wait_for(SEL_QTR, 300, n);
    check("m5_step1", n, S1 + 1);
    wait_for(SEL_HALF, 300, n);
    check("m5_half2", n, S2 - S1);
    wait_for(SEL_QTR, 300, n);
    check("m5_step3", n, S3 - S2);
    wait_for(SEL_QTR, 300, n);
    check("m5_step5", n, S5 - S3);
    check("m5_step5_half", halfframe, 1'b1);
    check("m5_no_irq", frame_irq, 1'b0);

    // reset during WAIT
    cpu_write(5'h15, 8'h1F);
    check("en_all", en, 5'h1F);
    cpu_write(5'h00, 8'h5A);
    check("p0_ctrl_pre_rst", p0_ctrl, 8'h5A);
    cpu_write(5'h17, 8'h80);
    step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_wait_no_tick", {qtrframe, halfframe}, 2'b00);
    end
    check("rst_wait_regs", {en, p0_ctrl, p0_ctrl_update, frame_irq}, 15'd0);
    addr = 5'h15;
    #1 check("rst_wait_rdata", rdata, 8'h15);
    rst = 1'b0;
    wait_for(SEL_QTR, 300, n);
    check("post_rst_step1", n, S1 + 1);
    wait_for(SEL_IRQ, 300, n);
    check("post_rst_4step_irq", n, S4 - 1 - S1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
